// File: rtl/sat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sat_pkg
//  Description : Shared geometry, literal/clause types and FSM encoding for
//                the clause evaluator.
//  Revision    : 1.0 - initial release
// ============================================================================
package sat_pkg;

    localparam int NUM_CLAUSES           = 64;
    localparam int VAR_ID_BITS           = 8;
    localparam int NUM_CLAUSES_PER_CYCLE = 16;
    localparam int NUM_VARS_PER_CLAUSE   = 3;

    localparam int NUM_VARS = 2 ** VAR_ID_BITS;
    localparam int LIT_W    = VAR_ID_BITS + 1;
    localparam int CLAUSE_W = NUM_VARS_PER_CLAUSE * LIT_W;
    localparam int SLICE_W  = NUM_CLAUSES_PER_CYCLE * CLAUSE_W;
    localparam int NUM_ROWS = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE;
    localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CIDX_W   = $clog2(NUM_CLAUSES);

    // Literal: bit0 = negation, upper bits = variable id (0 = padding)
    typedef struct packed {
        logic [VAR_ID_BITS-1:0] var_id;
        logic                   neg;
    } lit_t;

    // Literal j occupies bits [j*LIT_W +: LIT_W] of the clause
    typedef lit_t [NUM_VARS_PER_CLAUSE-1:0] clause_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_SWEEP = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Global clause index of slot k in a given row
    function automatic logic [CIDX_W-1:0] clause_index(input logic [ROW_W-1:0] row,
                                                        input int               k);
        return CIDX_W'(int'(row) * NUM_CLAUSES_PER_CYCLE + k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/single_clause_eval.sv
`default_nettype none
// ============================================================================
//  Module      : single_clause_eval
//  Description : Combinational evaluation of one 3-literal clause against the
//                current partial assignment (sat / conflict / unit / null).
//  Revision    : 1.0 - initial release
// ============================================================================
module single_clause_eval
    import sat_pkg::*;
(
    input  clause_t             i_clause,
    input  logic [NUM_VARS-1:0] i_assign_val,
    input  logic [NUM_VARS-1:0] i_assign_def,
    output logic                o_sat,
    output logic                o_conflict,
    output logic                o_unit,
    output logic                o_null,
    output lit_t                o_unit_lit
);

    logic [NUM_VARS_PER_CLAUSE-1:0] w_pad;
    logic [NUM_VARS_PER_CLAUSE-1:0] w_true;
    logic [NUM_VARS_PER_CLAUSE-1:0] w_unas;
    logic                           w_one_unas;

    // Classify each literal; padding (var 0) is treated as assigned-false
    for (genvar j = 0; j < NUM_VARS_PER_CLAUSE; j++) begin : g_lit
        logic w_def;
        logic w_val;
        assign w_def     = i_assign_def[i_clause[j].var_id];
        assign w_val     = i_assign_val[i_clause[j].var_id];
        assign w_pad[j]  = (i_clause[j].var_id == '0);
        assign w_true[j] = !w_pad[j] && w_def && (w_val ^ i_clause[j].neg);
        assign w_unas[j] = !w_pad[j] && !w_def;
    end

    // Exactly one unassigned literal: non-zero and a power of two
    assign w_one_unas = (w_unas != '0) &&
                        ((w_unas & (w_unas - NUM_VARS_PER_CLAUSE'(1))) == '0);

    assign o_null     = &w_pad;
    assign o_sat      = |w_true;
    assign o_conflict = !o_sat && (w_unas == '0) && !o_null;
    assign o_unit     = !o_sat && w_one_unas;

    // Pick the unassigned literal (only meaningful when o_unit is set)
    always_comb begin
        o_unit_lit = '0;
        for (int j = NUM_VARS_PER_CLAUSE - 1; j >= 0; j--) begin
            if (w_unas[j]) begin
                o_unit_lit = i_clause[j];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clause_evaluator.sv
`default_nettype none
// ============================================================================
//  Module      : clause_evaluator
//  Description : Sweeps all clause rows streamed from the clause store,
//                evaluates every clause against the assignment and reports
//                all-satisfied, first conflict and first unit clause.
//                Geometry is taken from sat_pkg.
//  Revision    : 1.0 - initial release
// ============================================================================
module clause_evaluator
    import sat_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [ROW_W-1:0]    in_row,
    input  logic [SLICE_W-1:0]  in_slice,
    input  logic [NUM_VARS-1:0] assign_val,
    input  logic [NUM_VARS-1:0] assign_def,
    output logic                busy,
    output logic                done,
    output logic                all_sat,
    output logic                conflict,
    output logic [CIDX_W-1:0]   conflict_idx,
    output logic                unit_found,
    output logic [CIDX_W-1:0]   unit_idx,
    output logic [LIT_W-1:0]    unit_lit
);

    localparam int               NCPC     = NUM_CLAUSES_PER_CYCLE;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    state_t             r_state;
    logic [ROW_W-1:0]   r_exp_row;
    logic               r_drain_cnt;
    logic               w_accept;
    logic               w_clear;

    // Stage 1: accepted slice
    logic               r_s1_valid;
    logic [ROW_W-1:0]   r_s1_row;
    logic [SLICE_W-1:0] r_s1_slice;

    // Combinational per-clause results of stage 1
    logic [NCPC-1:0]    w_sat;
    logic [NCPC-1:0]    w_conf;
    logic [NCPC-1:0]    w_unit;
    logic [NCPC-1:0]    w_null;
    lit_t [NCPC-1:0]    w_ulit;

    // Stage 2: registered per-clause flags
    logic               r_s2_valid;
    logic [ROW_W-1:0]   r_s2_row;
    logic [NCPC-1:0]    r_s2_ok;
    logic [NCPC-1:0]    r_s2_conf;
    logic [NCPC-1:0]    r_s2_unit;
    lit_t [NCPC-1:0]    r_s2_ulit;

    // Priority-encoded row summary
    logic               w_conf_hit;
    logic [CIDX_W-1:0]  w_conf_idx;
    logic               w_unit_hit;
    logic [CIDX_W-1:0]  w_unit_idx;
    lit_t               w_unit_lit;
    logic               r_acc_first;

    assign w_accept = in_valid &&
                      (((r_state == ST_SYNC)  && (in_row == '0)) ||
                       ((r_state == ST_SWEEP) && (in_row == r_exp_row)));
    assign w_clear  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Sweep control: sync to row 0, take rows in order, drain, pulse done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_exp_row   <= '0;
            r_drain_cnt <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_SYNC;
                        busy    <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (w_accept) begin
                        r_exp_row   <= ROW_ONE;
                        r_drain_cnt <= 1'b0;
                        r_state     <= (LAST_ROW == '0) ? ST_DRAIN : ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (w_accept) begin
                        if (r_exp_row == LAST_ROW) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= 1'b0;
                        end else begin
                            r_exp_row <= r_exp_row + ROW_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Two cycles lets the last row reach the accumulators
                    if (r_drain_cnt) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Evaluate every clause of the registered slice in parallel
    for (genvar k = 0; k < NCPC; k++) begin : g_clause
        clause_t w_clause;
        assign w_clause = r_s1_slice[k*CLAUSE_W +: CLAUSE_W];
        single_clause_eval u_eval (
            .i_clause     (w_clause),
            .i_assign_val (assign_val),
            .i_assign_def (assign_def),
            .o_sat        (w_sat[k]),
            .o_conflict   (w_conf[k]),
            .o_unit       (w_unit[k]),
            .o_null       (w_null[k]),
            .o_unit_lit   (w_ulit[k])
        );
    end

    // Two-stage pipeline: capture slice, then register per-clause flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_row   <= '0;
            r_s1_slice <= '0;
            r_s2_valid <= 1'b0;
            r_s2_row   <= '0;
            r_s2_ok    <= '0;
            r_s2_conf  <= '0;
            r_s2_unit  <= '0;
            r_s2_ulit  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_row   <= in_row;
                r_s1_slice <= in_slice;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_row  <= r_s1_row;
                r_s2_ok   <= w_sat | w_null;
                r_s2_conf <= w_conf;
                r_s2_unit <= w_unit;
                r_s2_ulit <= w_ulit;
            end
        end
    end

    // Lowest-k priority encoder over the registered row flags
    always_comb begin
        w_conf_hit = 1'b0;
        w_conf_idx = '0;
        w_unit_hit = 1'b0;
        w_unit_idx = '0;
        w_unit_lit = '0;
        for (int k = NCPC - 1; k >= 0; k--) begin
            if (r_s2_conf[k]) begin
                w_conf_hit = 1'b1;
                w_conf_idx = clause_index(r_s2_row, k);
            end
            if (r_s2_unit[k]) begin
                w_unit_hit = 1'b1;
                w_unit_idx = clause_index(r_s2_row, k);
                w_unit_lit = r_s2_ulit[k];
            end
        end
    end

    // Result accumulation; first capture wins so rows arrive lowest-first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_sat      <= 1'b0;
            conflict     <= 1'b0;
            conflict_idx <= '0;
            unit_found   <= 1'b0;
            unit_idx     <= '0;
            unit_lit     <= '0;
            r_acc_first  <= 1'b0;
        end else if (w_clear) begin
            all_sat      <= 1'b0;
            conflict     <= 1'b0;
            conflict_idx <= '0;
            unit_found   <= 1'b0;
            unit_idx     <= '0;
            unit_lit     <= '0;
            r_acc_first  <= 1'b1;
        end else if (r_s2_valid) begin
            r_acc_first <= 1'b0;
            all_sat     <= r_acc_first ? (&r_s2_ok) : (all_sat & (&r_s2_ok));
            if (!conflict && w_conf_hit) begin
                conflict     <= 1'b1;
                conflict_idx <= w_conf_idx;
            end
            if (!unit_found && w_unit_hit) begin
                unit_found <= 1'b1;
                unit_idx   <= w_unit_idx;
                unit_lit   <= w_unit_lit;
            end
        end
    end

endmodule
`default_nettype wire
